// File: rtl/tdm_demux_pkg.sv
// Shared constants, state encoding and channel-search helper for the TDM demux controller.
package tdm_demux_pkg;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        RUN
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] first_en(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/next_ch_find.sv
// Priority search for the lowest enabled channel above cur, or the lowest overall on a frame start.
module next_ch_find
    import tdm_demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              from_start,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    logic [NUM_CH-1:0] at_or_below;
    logic [NUM_CH-1:0] cand;

    always_comb begin
        // cur=15 yields all ones, leaving nothing above
        at_or_below = NUM_CH'((32'd2 << cur) - 32'd1);
        cand        = from_start ? mask : (mask & ~at_or_below);
        next        = first_en(cand);
        found       = |cand;
    end

endmodule

// File: rtl/tdm_demux_ctrl.sv
// Sequences a 16-way demux from a framed serial stream: one slot of (slot_len+1) bits per enabled channel.
module tdm_demux_ctrl
    import tdm_demux_pkg::*;
#(
    parameter int unsigned SLOT_W = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [SLOT_W-1:0] slot_len,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              frame_sync,
    output logic [SEL_W-1:0]  select_4,
    output logic              data_in_16,
    output logic              data_valid,
    output logic              slot_start,
    output logic              frame_done,
    output logic              sync_err,
    output logic              cfg_err,
    output logic              busy
);

    state_t state, state_n;

    logic [SEL_W-1:0]  cur_ch, cur_n;
    logic [SLOT_W-1:0] bit_cnt, cnt_n;
    logic [NUM_CH-1:0] mask_q, mask_n;
    logic [SLOT_W-1:0] len_q, len_n;
    logic              cont_q, cont_n;

    logic [SEL_W-1:0]  first_ch, adv_ch, ch;
    logic              first_found, adv_found;
    logic [SLOT_W-1:0] cnt;
    logic              take, slot_end, last;

    logic [SEL_W-1:0]  sel_n;
    logic              din_n, dv_n, ss_n, fd_n, se_n, ce_n, busy_n;

    next_ch_find u_first (
        .mask       (mask_q),
        .cur        (cur_ch),
        .from_start (1'b1),
        .next       (first_ch),
        .found      (first_found)
    );

    next_ch_find u_adv (
        .mask       (mask_q),
        .cur        (ch),
        .from_start (1'b0),
        .next       (adv_ch),
        .found      (adv_found)
    );

    // Decode of the incoming bit: which channel/count it lands on and whether it closes slot or frame.
    always_comb begin
        take     = !stop && bit_valid &&
                   ((state == RUN) || ((state == WAIT_SYNC) && frame_sync && first_found));
        ch       = frame_sync ? first_ch : cur_ch;
        cnt      = frame_sync ? '0 : bit_cnt;
        slot_end = (cnt == len_q);
        last     = slot_end && !adv_found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (|ch_mask)) state_n = WAIT_SYNC;
                end
                WAIT_SYNC, RUN: begin
                    if (take) begin
                        if (last) state_n = cont_q ? WAIT_SYNC : IDLE;
                        else      state_n = RUN;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        cur_n  = cur_ch;
        cnt_n  = bit_cnt;
        mask_n = mask_q;
        len_n  = len_q;
        cont_n = cont_q;
        sel_n  = select_4;
        din_n  = 1'b0;
        dv_n   = 1'b0;
        ss_n   = 1'b0;
        fd_n   = 1'b0;
        se_n   = 1'b0;
        ce_n   = 1'b0;

        if (!stop && (state == IDLE) && start) begin
            if (|ch_mask) begin
                mask_n = ch_mask;
                len_n  = slot_len;
                cont_n = continuous;
                cur_n  = '0;
                cnt_n  = '0;
            end else begin
                ce_n = 1'b1;
            end
        end

        if (take) begin
            sel_n = ch;
            din_n = bit_in;
            dv_n  = 1'b1;
            ss_n  = (cnt == '0);
            se_n  = (state == RUN) && frame_sync;
            fd_n  = last;
            if (slot_end) begin
                cnt_n = '0;
                cur_n = adv_found ? adv_ch : ch;
            end else begin
                cnt_n = cnt + SLOT_W'(1);
                cur_n = ch;
            end
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch     <= '0;
            bit_cnt    <= '0;
            mask_q     <= '0;
            len_q      <= '0;
            cont_q     <= 1'b0;
            select_4   <= '0;
            data_in_16 <= 1'b0;
            data_valid <= 1'b0;
            slot_start <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cur_ch     <= cur_n;
            bit_cnt    <= cnt_n;
            mask_q     <= mask_n;
            len_q      <= len_n;
            cont_q     <= cont_n;
            select_4   <= sel_n;
            data_in_16 <= din_n;
            data_valid <= dv_n;
            slot_start <= ss_n;
            frame_done <= fd_n;
            sync_err   <= se_n;
            cfg_err    <= ce_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_tdm_demux_ctrl.sv
// Directed self-checking bench for tdm_demux_ctrl.
module tb_tdm_demux_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, continuous;
    logic [15:0] ch_mask;
    logic [3:0]  slot_len;
    logic        bit_valid, bit_in, frame_sync;
    logic [3:0]  select_4;
    logic        data_in_16, data_valid, slot_start, frame_done, sync_err, cfg_err, busy;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_demux_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .slot_len   (slot_len),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .frame_sync (frame_sync),
        .select_4   (select_4),
        .data_in_16 (data_in_16),
        .data_valid (data_valid),
        .slot_start (slot_start),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    task automatic idle_inputs();
        start = 0; stop = 0; bit_valid = 0; bit_in = 0; frame_sync = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] m, input logic [3:0] l, input logic c);
        ch_mask = m; slot_len = l; continuous = c; start = 1;
        cycle();
        start = 0; ch_mask = 16'h0; slot_len = 4'h0; continuous = 0;
    endtask

    task automatic drive_bit(input logic b, input logic fs);
        bit_valid = 1; bit_in = b; frame_sync = fs;
        cycle();
        bit_valid = 0; bit_in = 0; frame_sync = 0;
    endtask

    task automatic gap();
        bit_valid = 0; bit_in = 1; frame_sync = 1;
        cycle();
        bit_in = 0; frame_sync = 0;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst = 1; idle_inputs(); ch_mask = '0; slot_len = '0; continuous = 0;
        #3;
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err, cfg_err, busy};
        checks++;
        if (got !== 11'h0) begin errs++; $display("FAIL reset_outs got=%b exp=%b", got, 11'h0); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        cycle();
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err, cfg_err, busy};
        checks++;
        if (got !== 11'h0) begin errs++; $display("FAIL reset_idle got=%b exp=%b", got, 11'h0); end
    endtask

    task automatic test_full_frame();
        logic [15:0] pat = 16'hA5C3;
        logic [8:0]  got, exp;
        do_start(16'hFFFF, 4'd0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errs++; $display("FAIL full_busy_arm got=%b exp=1", busy); end
        for (int i = 0; i < 16; i++) begin
            drive_bit(pat[i], i == 0);
            got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
            exp = {4'(i), pat[i], 1'b1, 1'b1, (i == 15), 1'b0};
            checks++;
            if (got !== exp) begin errs++; $display("FAIL full_bit%0d got=%b exp=%b", i, got, exp); end
        end
        cycle();
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, busy};
        exp = {4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin errs++; $display("FAIL full_after got=%b exp=%b", got, exp); end
    endtask

    task automatic test_gaps();
        logic [11:0] dat = 12'b1011_0011_1010;
        int          gaps[12] = '{0, 1, 0, 2, 0, 0, 1, 0, 3, 0, 1, 0};
        int          chans[4] = '{0, 5, 10, 15};
        logic [8:0]  got, exp;
        do_start(16'h8421, 4'd2, 1'b1);
        for (int k = 0; k < 12; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                gap();
                checks++;
                if ({data_valid, data_in_16} !== 2'b00) begin
                    errs++; $display("FAIL gap_dv k=%0d got=%b exp=00", k, {data_valid, data_in_16});
                end
                if (k > 0) begin
                    checks++;
                    if (select_4 !== 4'(chans[(k - 1) / 3])) begin
                        errs++; $display("FAIL gap_sel k=%0d got=%0d exp=%0d", k, select_4, chans[(k - 1) / 3]);
                    end
                end
            end
            drive_bit(dat[k], k == 0);
            got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
            exp = {4'(chans[k / 3]), dat[k], 1'b1, (k % 3 == 0), (k == 11), 1'b0};
            checks++;
            if (got !== exp) begin errs++; $display("FAIL gaps_bit%0d got=%b exp=%b", k, got, exp); end
        end
        checks++;
        if (busy !== 1'b1) begin errs++; $display("FAIL gaps_rearm_busy got=%b exp=1", busy); end
        drive_bit(1'b1, 1'b0);
        checks++;
        if (data_valid !== 1'b0) begin errs++; $display("FAIL gaps_nosync_discard got=%b exp=0", data_valid); end
        drive_bit(1'b1, 1'b1);
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
        exp = {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin errs++; $display("FAIL gaps_reframe got=%b exp=%b", got, exp); end
        stop = 1;
        cycle();
        stop = 0;
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL gaps_stop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_sync_err();
        logic [8:0] got, exp;
        logic       d;
        do_start(16'hFFFF, 4'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            d = (i % 3 == 1);
            drive_bit(d, i == 0);
            got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
            exp = {4'(i / 2), d, 1'b1, (i % 2 == 0), 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin errs++; $display("FAIL sync_pre%0d got=%b exp=%b", i, got, exp); end
        end
        drive_bit(1'b1, 1'b1);
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
        exp = {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (got !== exp) begin errs++; $display("FAIL sync_err_bit got=%b exp=%b", got, exp); end
        for (int i = 1; i < 32; i++) begin
            d = (i % 3 == 0);
            drive_bit(d, 1'b0);
            got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
            exp = {4'(i / 2), d, 1'b1, (i % 2 == 0), (i == 31), 1'b0};
            checks++;
            if (got !== exp) begin errs++; $display("FAIL sync_post%0d got=%b exp=%b", i, got, exp); end
        end
        cycle();
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL sync_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_cfg_err();
        logic [8:0] got, exp;
        do_start(16'h0000, 4'd0, 1'b0);
        checks++;
        if ({cfg_err, busy} !== 2'b10) begin errs++; $display("FAIL cfg_err_pulse got=%b exp=10", {cfg_err, busy}); end
        cycle();
        checks++;
        if ({cfg_err, busy} !== 2'b00) begin errs++; $display("FAIL cfg_err_clear got=%b exp=00", {cfg_err, busy}); end
        do_start(16'h0010, 4'd0, 1'b0);
        checks++;
        if ({cfg_err, busy} !== 2'b01) begin errs++; $display("FAIL cfg_single_arm got=%b exp=01", {cfg_err, busy}); end
        drive_bit(1'b1, 1'b1);
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
        exp = {4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin errs++; $display("FAIL cfg_single_bit got=%b exp=%b", got, exp); end
        cycle();
        checks++;
        if ({frame_done, busy} !== 2'b00) begin errs++; $display("FAIL cfg_single_end got=%b exp=00", {frame_done, busy}); end
    endtask

    task automatic test_stop();
        logic [8:0] got, exp;
        do_start(16'hFFFF, 4'd3, 1'b1);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        stop = 1; start = 1; ch_mask = 16'h0001; bit_valid = 1; bit_in = 1;
        cycle();
        idle_inputs(); ch_mask = 16'h0;
        checks++;
        if ({select_4, data_valid, data_in_16, frame_done, busy} !== 8'b0000_0000) begin
            errs++; $display("FAIL stop_cycle got=%b exp=%b",
                             {select_4, data_valid, data_in_16, frame_done, busy}, 8'b0);
        end
        drive_bit(1'b1, 1'b1);
        checks++;
        if ({data_valid, busy} !== 2'b00) begin errs++; $display("FAIL stop_ignore got=%b exp=00", {data_valid, busy}); end
        do_start(16'h0002, 4'd0, 1'b0);
        drive_bit(1'b1, 1'b1);
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err};
        exp = {4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin errs++; $display("FAIL stop_restart got=%b exp=%b", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        do_start(16'hFFFF, 4'd0, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        checks++;
        if ({select_4, data_valid} !== 5'b0010_1) begin
            errs++; $display("FAIL rstmid_pre got=%b exp=%b", {select_4, data_valid}, 5'b00101);
        end
        #2 rst = 1;
        #1;
        got = {select_4, data_in_16, data_valid, slot_start, frame_done, sync_err, cfg_err, busy};
        checks++;
        if (got !== 11'h0) begin errs++; $display("FAIL rstmid_async got=%b exp=%b", got, 11'h0); end
        bit_valid = 1; bit_in = 1; frame_sync = 1;
        @(posedge clk);
        @(negedge clk) rst = 0;
        cycle();
        idle_inputs();
        checks++;
        if ({data_valid, busy} !== 2'b00) begin errs++; $display("FAIL rstmid_idle got=%b exp=00", {data_valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_sync_err();
        test_cfg_err();
        test_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
